// File: rtl/register_file_scoreboard_pkg.sv
// Shared constants and types for the register file / scoreboard slice.
//   REG_COUNT      : number of stored architectural registers (R0..R14)
//   PC_INDEX       : register index that aliases the PC and is never stored
//   DATA_WIDTH     : register data width
//   SB_COUNT_WIDTH : width of each per-register in-flight write counter
package register_file_scoreboard_pkg;

  localparam int unsigned REG_COUNT      = 15;
  localparam logic [3:0]  PC_INDEX       = 4'd15;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned SB_COUNT_WIDTH = 2;

  typedef logic [3:0]                reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;
  typedef logic [SB_COUNT_WIDTH-1:0] sb_count_t;

endpackage

// File: rtl/register_file_scoreboard_sb_counter.sv
// sb_counter: saturating up/down counter tracking in-flight writes to one
// register.
//   clk, rst : core clock, synchronous active-high reset
//   inc      : an instruction writing this register was issued
//   dec      : a write to this register committed at write-back
//   count    : current number of in-flight writes
//   error    : combinational pulse, high when this cycle's request would
//              overflow (inc at max) or underflow (dec at zero)
module sb_counter
  import register_file_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      dec,
  output sb_count_t count,
  output logic      error
);

  logic inc_only;
  logic dec_only;
  logic at_max;
  logic at_zero;

  always_comb begin
    inc_only = inc && !dec;
    dec_only = dec && !inc;
    at_max   = (count == '1);
    at_zero  = (count == '0);
    error    = (inc_only && at_max) || (dec_only && at_zero);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_only && !at_max) begin
      count <= count + sb_count_t'(1);
    end else if (dec_only && !at_zero) begin
      count <= count - sb_count_t'(1);
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: 15 x 32-bit register file with R15 mapped to the
// PC, write-through bypass on both read ports, and a per-register scoreboard
// of in-flight writes with a sticky protocol-error flag.
//   clk, rst                       : core clock, synchronous active-high reset
//   wb_enable, wb_dest, wb_value   : write-back port (also retires a pending write)
//   src1, src2                     : read indices
//   pc_in                          : value returned for reads of R15
//   issue_enable, issue_dest       : new in-flight write entering execute
//   reg1, reg2                     : read data (combinational)
//   src1_busy, src2_busy           : read index has an uncommitted write
//   sb_error                       : sticky over/underflow flag
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_enable,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic [31:0] pc_in,
  input  logic        issue_enable,
  input  logic [3:0]  issue_dest,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic        src1_busy,
  output logic        src2_busy,
  output logic        sb_error
);

  reg_data_t            regs   [REG_COUNT];
  sb_count_t            counts [REG_COUNT];
  logic [REG_COUNT-1:0] cnt_err;

  logic wb_write;
  logic issue_write;

  always_comb begin
    wb_write    = wb_enable && (wb_dest != PC_INDEX);
    issue_write = issue_enable && (issue_dest != PC_INDEX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_write) begin
      regs[wb_dest] <= wb_value;
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_sb
    sb_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (issue_write && (issue_dest == reg_idx_t'(g))),
      .dec   (wb_write && (wb_dest == reg_idx_t'(g))),
      .count (counts[g]),
      .error (cnt_err[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_error <= 1'b0;
    end else if (|cnt_err) begin
      sb_error <= 1'b1;
    end
  end

  function automatic reg_data_t read_port(input reg_idx_t src, input reg_data_t stored);
    if (src == PC_INDEX) begin
      return pc_in;
    end else if (wb_write && (wb_dest == src)) begin
      return wb_value;
    end
    return stored;
  endfunction

  // A write committing this cycle already retires one pending count, so the
  // register is busy only if more than that one write is outstanding.
  function automatic logic busy_of(input reg_idx_t src, input sb_count_t cnt);
    if (src == PC_INDEX) begin
      return 1'b0;
    end else if (wb_write && (wb_dest == src)) begin
      return cnt > sb_count_t'(1);
    end
    return cnt != '0;
  endfunction

  always_comb begin
    reg1      = '0;
    reg2      = '0;
    src1_busy = 1'b0;
    src2_busy = 1'b0;
    if (src1 != PC_INDEX) begin
      reg1      = read_port(src1, regs[src1]);
      src1_busy = busy_of(src1, counts[src1]);
    end else begin
      reg1 = pc_in;
    end
    if (src2 != PC_INDEX) begin
      reg2      = read_port(src2, regs[src2]);
      src2_busy = busy_of(src2, counts[src2]);
    end else begin
      reg2 = pc_in;
    end
  end

endmodule
